// File: rtl/mem_arbiter_if.sv
// Single-port memory handshake shared by the instruction, data and external memory sides.
// The requester drives address/write fields and holds access until it sees a one-cycle ack.
interface mem_arbiter_if;
    logic [18:0] addr;
    logic [15:0] data_out;
    logic        access;
    logic        wr_en;
    logic [1:0]  bytesel;
    logic        ack;
    logic [15:0] data_in;

    modport master (
        output addr,
        output data_out,
        output access,
        output wr_en,
        output bytesel,
        input  ack,
        input  data_in
    );

    modport slave (
        input  addr,
        input  data_out,
        input  access,
        input  wr_en,
        input  bytesel,
        output ack,
        output data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one external memory port between instruction prefetch and data load/store.
// Data wins ties, but after DATA_BURST_MAX back-to-back data grants a waiting fetch is forced through.
module mem_arbiter #(
    parameter int DATA_BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  instr_m,
    mem_arbiter_if.slave  data_m,
    mem_arbiter_if.master q_m
);

    localparam int RUN_W = $clog2(DATA_BURST_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DATA_BURST_MAX);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [RUN_W-1:0] data_run_reg;
    logic [RUN_W-1:0] data_run_next;

    logic [18:0] q_addr;
    logic [15:0] q_data_out;
    logic        q_access;
    logic        q_wr_en;
    logic [1:0]  q_bytesel;
    logic        instr_ack;
    logic        data_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            data_run_reg <= '0;
        end else begin
            state_reg    <= state_next;
            data_run_reg <= data_run_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        data_run_next = data_run_reg;
        q_addr        = '0;
        q_data_out    = '0;
        q_access      = 1'b0;
        q_wr_en       = 1'b0;
        q_bytesel     = 2'b00;
        instr_ack     = 1'b0;
        data_ack      = 1'b0;

        case (state_reg)
            IDLE: begin
                // The shared port stays quiet here, so a stray memory ack is simply ignored.
                if (instr_m.access && data_m.access) begin
                    state_next = (data_run_reg == RUN_MAX) ? GNT_I : GNT_D;
                end else if (instr_m.access) begin
                    state_next = GNT_I;
                end else if (data_m.access) begin
                    state_next = GNT_D;
                end

                if (!instr_m.access) begin
                    data_run_next = '0;
                end else if (state_next == GNT_I) begin
                    data_run_next = '0;
                end else if ((state_next == GNT_D) && (data_run_reg != RUN_MAX)) begin
                    data_run_next = data_run_reg + RUN_ONE;
                end
            end

            GNT_I: begin
                q_addr    = instr_m.addr;
                q_access  = instr_m.access;
                q_bytesel = 2'b11;
                instr_ack = q_m.ack & instr_m.access;
                // Completion or an abandoned request both return to IDLE.
                if (q_m.ack || !instr_m.access) begin
                    state_next = IDLE;
                end
            end

            GNT_D: begin
                q_addr     = data_m.addr;
                q_data_out = data_m.data_out;
                q_access   = data_m.access;
                q_wr_en    = data_m.wr_en;
                q_bytesel  = data_m.bytesel;
                data_ack   = q_m.ack & data_m.access;
                if (q_m.ack || !data_m.access) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign q_m.addr     = q_addr;
    assign q_m.data_out = q_data_out;
    assign q_m.access   = q_access;
    assign q_m.wr_en    = q_wr_en;
    assign q_m.bytesel  = q_bytesel;

    assign instr_m.ack  = instr_ack;
    assign data_m.ack   = data_ack;

    // Read data is shared by both masters; each qualifies it with its own ack.
    assign instr_m.data_in = q_m.data_in;
    assign data_m.data_in  = q_m.data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, reads, tie-break, fetch anti-starvation, writes, aborts.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if ii ();
    mem_arbiter_if di ();
    mem_arbiter_if qi ();

    mem_arbiter #(.DATA_BURST_MAX(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .instr_m (ii),
        .data_m  (di),
        .q_m     (qi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic        exp_is_i [6];
    logic [18:0] exp_addr;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        ii.addr = '0; ii.data_out = '0; ii.access = 1'b0; ii.wr_en = 1'b0; ii.bytesel = 2'b00;
        di.addr = '0; di.data_out = '0; di.access = 1'b0; di.wr_en = 1'b0; di.bytesel = 2'b00;
        qi.ack = 1'b0;
        qi.data_in = 16'h1234;
        exp_is_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state and unregistered read-data passthrough
        mid();
        chk("rst_q_access", qi.access, 0);
        chk("rst_q_addr", qi.addr, 0);
        chk("rst_q_wr_en", qi.wr_en, 0);
        chk("rst_q_bytesel", qi.bytesel, 0);
        chk("rst_instr_ack", ii.ack, 0);
        chk("rst_data_ack", di.ack, 0);
        chk("rst_passthru_i", ii.data_in, 16'h1234);
        chk("rst_passthru_d", di.data_in, 16'h1234);
        tick();
        tick();
        reset = 1'b1;

        // Instruction read, 1-cycle grant latency, ack at c3
        tick();
        ii.addr = 19'h12345;
        ii.access = 1'b1;
        mid();
        chk("ird_c0_access", qi.access, 0);
        tick();
        mid();
        chk("ird_c1_access", qi.access, 1);
        chk("ird_c1_addr", qi.addr, 19'h12345);
        chk("ird_c1_bytesel", qi.bytesel, 2'b11);
        chk("ird_c1_wr_en", qi.wr_en, 0);
        chk("ird_c1_ack", ii.ack, 0);
        tick();
        tick();
        qi.ack = 1'b1;
        qi.data_in = 16'hBEEF;
        mid();
        chk("ird_c3_ack", ii.ack, 1);
        chk("ird_c3_data", ii.data_in, 16'hBEEF);
        chk("ird_c3_dack", di.ack, 0);
        tick();
        qi.ack = 1'b0;
        ii.access = 1'b0;
        mid();
        chk("ird_c4_access", qi.access, 0);
        chk("ird_c4_ack", ii.ack, 0);

        // Simultaneous requests: data first, then instr after one IDLE cycle
        tick();
        ii.addr = 19'h00111;
        ii.access = 1'b1;
        di.addr = 19'h54321;
        di.bytesel = 2'b11;
        di.access = 1'b1;
        tick();
        mid();
        chk("tie_c1_addr", qi.addr, 19'h54321);
        chk("tie_c1_access", qi.access, 1);
        tick();
        qi.ack = 1'b1;
        qi.data_in = 16'h0D0D;
        mid();
        chk("tie_dack", di.ack, 1);
        chk("tie_iack_quiet", ii.ack, 0);
        chk("tie_ddata", di.data_in, 16'h0D0D);
        tick();
        qi.ack = 1'b0;
        di.access = 1'b0;
        mid();
        chk("tie_bubble", qi.access, 0);
        tick();
        mid();
        chk("tie_i_addr", qi.addr, 19'h00111);
        chk("tie_i_access", qi.access, 1);
        tick();
        qi.ack = 1'b1;
        mid();
        chk("tie_iack", ii.ack, 1);
        chk("tie_dack_quiet", di.ack, 0);
        tick();
        qi.ack = 1'b0;
        ii.access = 1'b0;
        mid();
        chk("tie_end_access", qi.access, 0);

        // Starvation bound: expected grant order D D D D I D
        tick();
        ii.addr = 19'h0AAAA;
        ii.access = 1'b1;
        di.addr = 19'h0DDDD;
        di.access = 1'b1;
        for (int g = 0; g < 6; g++) begin
            exp_addr = exp_is_i[g] ? 19'h0AAAA : 19'h0DDDD;
            tick();
            qi.ack = 1'b1;
            mid();
            chk($sformatf("starve_g%0d_addr", g), qi.addr, exp_addr);
            chk($sformatf("starve_g%0d_iack", g), ii.ack, exp_is_i[g]);
            chk($sformatf("starve_g%0d_dack", g), di.ack, !exp_is_i[g]);
            tick();
            qi.ack = 1'b0;
            if (g == 5) begin
                ii.access = 1'b0;
                di.access = 1'b0;
            end
            mid();
            chk($sformatf("starve_g%0d_bubble", g), qi.access, 0);
        end

        // Data write fields forwarded; instr grant forces read fields
        tick();
        di.addr = 19'h00F0F;
        di.data_out = 16'hA55A;
        di.wr_en = 1'b1;
        di.bytesel = 2'b01;
        di.access = 1'b1;
        tick();
        qi.ack = 1'b1;
        mid();
        chk("wr_data_out", qi.data_out, 16'hA55A);
        chk("wr_bytesel", qi.bytesel, 2'b01);
        chk("wr_wr_en", qi.wr_en, 1);
        chk("wr_access", qi.access, 1);
        chk("wr_dack", di.ack, 1);
        tick();
        qi.ack = 1'b0;
        di.access = 1'b0;
        ii.addr = 19'h07777;
        ii.access = 1'b1;
        mid();
        chk("wr_idle_wr_en", qi.wr_en, 0);
        tick();
        qi.ack = 1'b1;
        mid();
        chk("wr_gnti_wr_en", qi.wr_en, 0);
        chk("wr_gnti_data_out", qi.data_out, 0);
        chk("wr_gnti_bytesel", qi.bytesel, 2'b11);
        chk("wr_gnti_addr", qi.addr, 19'h07777);
        chk("wr_gnti_iack", ii.ack, 1);
        tick();
        qi.ack = 1'b0;
        ii.access = 1'b0;
        di.wr_en = 1'b0;
        di.data_out = '0;
        di.bytesel = 2'b11;

        // Stray ack while idle
        tick();
        qi.ack = 1'b1;
        mid();
        chk("stray_iack", ii.ack, 0);
        chk("stray_dack", di.ack, 0);
        chk("stray_access", qi.access, 0);
        tick();
        qi.ack = 1'b0;

        // Reset pulse mid-GNT_D, late ack after release
        di.addr = 19'h13579;
        di.access = 1'b1;
        tick();
        mid();
        chk("rmid_granted", qi.access, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("rmid_async_access", qi.access, 0);
        chk("rmid_async_addr", qi.addr, 0);
        tick();
        mid();
        chk("rmid_held_access", qi.access, 0);
        tick();
        reset = 1'b1;
        qi.ack = 1'b1;
        mid();
        chk("rmid_late_dack", di.ack, 0);
        chk("rmid_late_access", qi.access, 0);
        tick();
        qi.ack = 1'b0;
        mid();
        chk("rmid_resume_access", qi.access, 1);
        chk("rmid_resume_addr", qi.addr, 19'h13579);
        tick();
        qi.ack = 1'b1;
        mid();
        chk("rmid_resume_dack", di.ack, 1);
        tick();
        qi.ack = 1'b0;
        di.access = 1'b0;

        // Abort of a data grant, pending instr served afterwards
        tick();
        di.addr = 19'h02468;
        di.access = 1'b1;
        ii.addr = 19'h03333;
        ii.access = 1'b1;
        tick();
        mid();
        chk("abort_gntd_addr", qi.addr, 19'h02468);
        chk("abort_gntd_access", qi.access, 1);
        #1;
        di.access = 1'b0;
        #1;
        chk("abort_same_cycle", qi.access, 0);
        chk("abort_no_dack", di.ack, 0);
        tick();
        mid();
        chk("abort_idle_access", qi.access, 0);
        tick();
        qi.ack = 1'b1;
        mid();
        chk("abort_i_addr", qi.addr, 19'h03333);
        chk("abort_i_access", qi.access, 1);
        chk("abort_i_iack", ii.ack, 1);
        tick();
        qi.ack = 1'b0;
        ii.access = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
